// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write path: the ppp (partial
// write pattern) encodings, the largest legal ppp code, and the requester
// indices used by the write arbiter.
// Ports: none (package).
// -----------------------------------------------------------------------------
package rf_pkg;

    // Partial-write patterns understood by the register file
    localparam logic [2:0] PPP_ALL  = 3'b000;
    localparam logic [2:0] PPP_HI   = 3'b001;
    localparam logic [2:0] PPP_LO   = 3'b010;
    localparam logic [2:0] PPP_EVEN = 3'b011;
    localparam logic [2:0] PPP_ODD  = 3'b100;
    localparam logic [2:0] PPP_MAX  = PPP_ODD;

    // Requester indices on the arbiter
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    // Codes above PPP_MAX have no meaning to the register file
    function automatic logic ppp_is_legal(input logic [2:0] ppp);
        return (ppp <= PPP_MAX);
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the two write requesters (index REQ_ALU / REQ_MEM), the register
// file write port and the status outputs of the write arbiter.
// Signals:
//   req_vld[1:0]        request valid per requester
//   req_rd[2]  (AW)     destination register per requester
//   req_ppp[2] (3)      partial-write pattern per requester
//   req_din[2] (DW)     write data per requester
//   req_rdy[1:0]        request accepted this cycle
//   wb_wen/wb_rd/wb_ppp/wb_din   register-file write port
//   err_ppp             sticky illegal-ppp flag
//   coll_cnt (4)        saturating contention-cycle count
// Modports: master (requester/observer side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic [1:0]    req_vld;
    logic [AW-1:0] req_rd  [2];
    logic [2:0]    req_ppp [2];
    logic [DW-1:0] req_din [2];
    logic [1:0]    req_rdy;

    logic          wb_wen;
    logic [AW-1:0] wb_rd;
    logic [2:0]    wb_ppp;
    logic [DW-1:0] wb_din;

    logic          err_ppp;
    logic [3:0]    coll_cnt;

    modport master (
        output req_vld, req_rd, req_ppp, req_din,
        input  req_rdy, wb_wen, wb_rd, wb_ppp, wb_din, err_ppp, coll_cnt
    );

    modport slave (
        input  req_vld, req_rd, req_ppp, req_din,
        output req_rdy, wb_wen, wb_rd, wb_ppp, wb_din, err_ppp, coll_cnt
    );
endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   vld[1:0]  request valid per requester
//   lgp       index of the requester granted last
//   gnt[1:0]  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] vld,
    input  logic       lgp,
    output logic [1:0] gnt
);
    // A lone requester always wins; on a tie the one not granted last wins.
    assign gnt[0] = vld[0] & (~vld[1] |  lgp);
    assign gnt[1] = vld[1] & (~vld[0] | ~lgp);
endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Arbitrates the ALU and MEM write requesters onto the single register-file
// write port. Acceptance is combinational (the RF never backpressures); the
// write appears on wb_* exactly one cycle after acceptance. Requests with an
// illegal ppp are accepted but dropped and raise the sticky err_ppp flag.
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   bus       rf_write_arbiter_if.slave (requests, RF write port, status)
// Parameters: DW data width, AW register address width (must match bus).
// Configuration macro:
//   RFWA_R0_DROP_EN  when defined, writes to register 0 are accepted but do
//                    not raise wb_wen.
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_write_arbiter_if.slave    bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]    r_state;
    logic          r_lgp;
    logic [AW-1:0] r_rd;
    logic [2:0]    r_ppp;
    logic [DW-1:0] r_din;
    logic          r_err;
    logic [3:0]    r_coll;

    logic [1:0]    w_gnt;
    logic [1:0]    w_rdy;
    logic          w_acc;
    logic          w_sel;
    logic [AW-1:0] w_rd;
    logic [2:0]    w_ppp;
    logic [DW-1:0] w_din;
    logic          w_legal;
    logic          w_drop;
    logic          w_issue;

    rr_arb2 u_rr_arb2 (
        .vld (bus.req_vld),
        .lgp (r_lgp),
        .gnt (w_gnt)
    );

    // Nothing is accepted while reset is held, so in-flight requests are lost.
    assign w_rdy = reset ? 2'b00 : w_gnt;
    assign w_acc = |w_rdy;
    assign w_sel = w_rdy[REQ_MEM];

    assign w_rd  = bus.req_rd[w_sel];
    assign w_ppp = bus.req_ppp[w_sel];
    assign w_din = bus.req_din[w_sel];

    assign w_legal = ppp_is_legal(w_ppp);

`ifdef RFWA_R0_DROP_EN
    assign w_drop = (w_rd == '0);
`else
    assign w_drop = 1'b0;
`endif

    // Only legal, non-dropped acceptances produce a write one cycle later.
    assign w_issue = w_acc & w_legal & ~w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_lgp   <= 1'b1;
            r_rd    <= '0;
            r_ppp   <= '0;
            r_din   <= '0;
            r_err   <= 1'b0;
            r_coll  <= '0;
        end else begin
            r_state <= w_issue ? ST_ISSUE : ST_IDLE;

            // Write fields only move on an issued write and hold otherwise.
            if (w_issue) begin
                r_rd  <= w_rd;
                r_ppp <= w_ppp;
                r_din <= w_din;
            end

            // Any acceptance, even a dropped one, advances the round-robin.
            if (w_acc) begin
                r_lgp <= w_sel;
            end

            if (w_acc && !w_legal) begin
                r_err <= 1'b1;
            end

            if ((&bus.req_vld) && (r_coll != 4'hF)) begin
                r_coll <= r_coll + 4'd1;
            end
        end
    end

    assign bus.req_rdy  = w_rdy;
    assign bus.wb_wen   = (r_state == ST_ISSUE);
    assign bus.wb_rd    = r_rd;
    assign bus.wb_ppp   = r_ppp;
    assign bus.wb_din   = r_din;
    assign bus.err_ppp  = r_err;
    assign bus.coll_cnt = r_coll;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DW, default 64, meaning the register data width.
REQ-002 SHALL have parameter AW, default 5, meaning the register address width.
REQ-003 SHALL have port clk, input, 1 bit: the clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports req_vld[i] (input, 1), req_rd[i] (input, AW), req_ppp[i] (input, 3) and req_din[i] (input, DW), for i = 0 (ALU) and i = 1 (MEM): write request.
REQ-006 SHALL have port req_rdy[i], output, 1 bit: request i accepted this cycle.
REQ-007 SHALL have ports wb_wen (output, 1), wb_rd (output, AW), wb_ppp (output, 3) and wb_din (output, DW): the register-file write port.
REQ-008 SHALL have port err_ppp, output, 1 bit: sticky flag, illegal ppp seen.
REQ-009 SHALL have port coll_cnt, output, 4 bits: saturating count of contention cycles.

Function
REQ-010 SHALL arbitrate both requesters onto the single RF write port, with at most one grant per cycle.
REQ-011 SHALL set req_rdy[i] combinationally from req_vld and the last-grant pointer lgp; the RF applies no backpressure.
REQ-012 SHALL grant the only valid requester when exactly one req_vld is high.
REQ-013 SHALL grant requester !lgp when both are valid (round-robin), then set lgp to the granted index.
REQ-014 SHALL keep lgp unchanged in cycles with no grant.
REQ-015 SHALL implement a two-state output FSM: IDLE (wb_wen=0) and ISSUE (wb_wen=1).
REQ-016 SHALL enter ISSUE on any accepted legal request and return to IDLE on a cycle with no accepted legal request.
REQ-017 SHALL register wb_rd, wb_ppp and wb_din from the granted request, giving a latency of exactly 1 cycle from accept to wb_wen.
REQ-018 SHALL treat ppp values 000-100 as legal and pass them unmodified.
REQ-019 SHALL accept (rdy=1) a request with ppp 101-111, suppress its wb_wen, and set err_ppp until reset.
REQ-020 SHALL hold wb_rd, wb_ppp and wb_din at their last value while in IDLE.
REQ-021 SHALL increment coll_cnt in each cycle with both req_vld high and saturate it at 15.
REQ-022 SHALL let back-to-back grants issue every cycle with no bubble, including alternating grants under sustained contention.
REQ-023 SHALL give an unaccepted request no ordering guarantee beyond round-robin; the requester holds its inputs stable while vld=1 and rdy=0.

Reset
REQ-024 SHALL, with reset high at a clk edge, clear the FSM to IDLE, wb_wen, wb_rd, wb_ppp, wb_din, err_ppp and coll_cnt to 0, and set lgp to 1.
REQ-025 SHALL drive req_rdy low while reset is high and drop any request in flight; no wb_wen follows reset.

Configuration
REQ-026 SHALL, with macro RFWA_R0_DROP_EN defined, accept requests with rd=0 but suppress their wb_wen (no slot consumed downstream).
REQ-027 SHALL, without RFWA_R0_DROP_EN, issue rd=0 requests normally; the RF ignores them.

Structure
REQ-028 SHALL take the ppp encodings (PPP_ALL=000, PPP_HI=001, PPP_LO=010, PPP_EVEN=011, PPP_ODD=100), PPP_MAX=100 and the requester indices from shared package rf_pkg.
REQ-029 SHALL place round-robin selection in one sub-module, rr_arb2 (inputs vld[1:0], lgp; output gnt[1:0]).

Verification
REQ-030 SHALL cover: req0 only, rd=3, ppp=000, din=64'h1122_3344_5566_7788 -> rdy0=1 same cycle; next cycle wb_wen=1, wb_rd=3, wb_din matches.
REQ-031 SHALL cover: both valid for 4 cycles from reset -> grants 0,1,0,1; wb_wen high for 4 consecutive cycles; coll_cnt=4.
REQ-032 SHALL cover: req1, ppp=110 -> rdy1=1, wb_wen stays 0, err_ppp=1 and stays 1 until reset.
REQ-033 SHALL cover: both valid held for 20 cycles -> coll_cnt saturates at 15.
REQ-034 SHALL cover: reset asserted in the cycle after a grant -> wb_wen=0 the following cycle, all outputs 0, first tie after reset goes to req0.
REQ-035 SHALL cover: rd=0 write -> with RFWA_R0_DROP_EN, wb_wen=0; without it, wb_wen=1 with wb_rd=0.
